// File: rtl/booth_pkg.sv
// Types and widths shared by the Booth multiplier datapath, the BCD converter
// and the 7-segment display driver.
package booth_pkg;

  localparam int unsigned PRODUCTO_W  = 16;
  localparam int unsigned BCD_DIGITOS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } estado_bcd_t;

endpackage

// File: rtl/ajuste_bcd_digito.sv
// Double-dabble add-3 correction for a single BCD digit (purely combinational).
module ajuste_bcd_digito (
  input  logic [3:0] digito_i,
  output logic [3:0] ajustado_c_o
);

  assign ajustado_c_o = (digito_i >= 4'd5) ? (digito_i + 4'd3) : digito_i;

endmodule

// File: rtl/bcd_con_signo.sv
// Sequential signed binary-to-BCD converter: one double-dabble step per clock,
// magnitude in packed BCD with the sign reported separately.
module bcd_con_signo
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH  = PRODUCTO_W,
  parameter int unsigned DIGITS = BCD_DIGITOS
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      producto,
  output logic                  busy,
  output logic                  done,
  output logic                  signo,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CAT_W = BCD_W + WIDTH;

  estado_bcd_t        estado_q, estado_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signo_r_q, signo_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               signo_q, signo_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   ajustado_c;
  logic [WIDTH-1:0]   mag_abs_c;
  logic [CAT_W-1:0]   desplazado_c;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign mag_abs_c = producto[WIDTH-1] ? (~producto + WIDTH'(1)) : producto;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_ajuste
    ajuste_bcd_digito u_ajuste (
      .digito_i     (scratch_q[g*4 +: 4]),
      .ajustado_c_o (ajustado_c[g*4 +: 4])
    );
  end

  assign desplazado_c = {ajustado_c, mag_q} << 1;

  // Next-state and output logic.
  always_comb begin
    estado_d  = estado_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    signo_r_d = signo_r_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    signo_d   = signo_q;
    bcd_d     = bcd_q;

    case (estado_q)
      IDLE: begin
        // A start landing in the done cycle belongs to FIN and is dropped.
        if (start && !done_q) begin
          signo_r_d = producto[WIDTH-1];
          mag_d     = mag_abs_c;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          estado_d  = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = desplazado_c[CAT_W-1:WIDTH];
        mag_d     = desplazado_c[WIDTH-1:0];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          estado_d = FIN;
        end
      end
      FIN: begin
        bcd_d    = scratch_q;
        signo_d  = signo_r_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      signo_r_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      signo_q   <= 1'b0;
      bcd_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      signo_r_q <= signo_r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      signo_q   <= signo_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign signo = signo_q;
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_bcd_con_signo.sv
// Directed bench for bcd_con_signo: expected {signo,bcd} queued at start,
// popped and compared on every done pulse.
module tb_bcd_con_signo;

  logic        CLK100MHZ = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] producto;
  logic        busy;
  logic        done;
  logic        signo;
  logic [19:0] bcd;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int hold_err  = 0;

  logic [20:0] exp_q[$];
  logic [20:0] e_mon;
  logic [19:0] held_bcd   = '0;
  logic        held_signo = 1'b0;
  logic        done_prev  = 1'b0;

  bcd_con_signo dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .start     (start),
    .producto  (producto),
    .busy      (busy),
    .done      (done),
    .signo     (signo),
    .bcd       (bcd)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: sign bit plus decimal digits of the magnitude.
  function automatic logic [20:0] model(input logic [15:0] p);
    int          m;
    logic [19:0] b;
    m = p[15] ? (65536 - int'(p)) : int'(p);
    for (int i = 0; i < 5; i++) begin
      b[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {p[15], b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer plus output-hold tracking.
  always @(negedge CLK100MHZ) begin
    if (!reset) begin
      held_bcd   = '0;
      held_signo = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        assert (!done_prev) else begin
          failures++;
          $error("FAIL done_width observed two consecutive done cycles expected one");
        end
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_done observed bcd=%h signo=%0b expected no done", bcd, signo);
        end
        if (exp_q.size() > 0) begin
          e_mon = exp_q.pop_front();
          checks++;
          assert ({signo, bcd} === e_mon) else begin
            failures++;
            $error("FAIL result observed signo=%0b bcd=%h expected signo=%0b bcd=%h",
                   signo, bcd, e_mon[20], e_mon[19:0]);
          end
          held_bcd   = e_mon[19:0];
          held_signo = e_mon[20];
        end
      end else if (bcd !== held_bcd || signo !== held_signo) begin
        hold_err++;
      end
      done_prev = done;
    end
  end

  // One conversion; optional extra start pulse at cycle second_at (0 = none).
  task automatic conv(input logic [15:0] val, input int second_at, input logic [15:0] val2,
                      output int lat, output int busy_cyc);
    @(negedge CLK100MHZ);
    start    = 1'b1;
    producto = val;
    exp_q.push_back(model(val));
    @(posedge CLK100MHZ);
    #1;
    start    = 1'b0;
    lat      = 1;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 40) begin
      if (second_at != 0 && lat == second_at) begin
        start    = 1'b1;
        producto = val2;
      end else begin
        start    = 1'b0;
      end
      @(posedge CLK100MHZ);
      #1;
      lat++;
      if (busy === 1'b1) busy_cyc++;
    end
    start = 1'b0;
  endtask

  int lat, bc, d0;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    producto = '0;
    #3;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_signo", 32'(signo), 32'd0);
    chk("rst_bcd",   32'(bcd),   32'd0);
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b1;

    conv(16'h4000, 0, 16'h0, lat, bc);
    chk("lat_16384",  32'(lat), 32'd18);
    chk("busy_16384", 32'(bc),  32'd17);
    chk("const_16384", 32'(bcd), 32'h16384);
    repeat (2) @(posedge CLK100MHZ);

    conv(16'hC080, 0, 16'h0, lat, bc);
    chk("lat_m16256", 32'(lat), 32'd18);
    chk("const_m16256", 32'(bcd), 32'h16256);
    chk("sign_m16256", 32'(signo), 32'd1);
    repeat (2) @(posedge CLK100MHZ);

    // Asynchronous reset 8 cycles into a conversion.
    @(negedge CLK100MHZ);
    start    = 1'b1;
    producto = 16'h1111;
    exp_q.push_back(model(16'h1111));
    @(posedge CLK100MHZ);
    #1;
    start = 1'b0;
    repeat (8) @(posedge CLK100MHZ);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(done),  32'd0);
    chk("arst_signo", 32'(signo), 32'd0);
    chk("arst_bcd",   32'(bcd),   32'd0);
    exp_q.delete();
    d0 = done_cnt;
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ);
    reset = 1'b1;
    repeat (25) @(posedge CLK100MHZ);
    #1;
    chk("arst_no_done", 32'(done_cnt), 32'(d0));
    chk("arst_idle",    32'(busy),     32'd0);

    conv(16'h8000, 0, 16'h0, lat, bc);
    chk("lat_min", 32'(lat), 32'd18);
    chk("const_min", 32'({signo, bcd}), 32'h132768);
    repeat (2) @(posedge CLK100MHZ);
    conv(16'h0000, 0, 16'h0, lat, bc);
    chk("lat_zero", 32'(lat), 32'd18);
    repeat (2) @(posedge CLK100MHZ);

    // Second start while busy is dropped.
    d0 = done_cnt;
    conv(16'h1234, 5, 16'h0999, lat, bc);
    chk("ign_lat",  32'(lat), 32'd18);
    chk("ign_busy", 32'(bc),  32'd17);
    repeat (25) @(posedge CLK100MHZ);
    #1;
    chk("ign_one_done", 32'(done_cnt), 32'(d0 + 1));

    // Back-to-back: new start one cycle after the done cycle.
    conv(16'h0457, 0, 16'h0, lat, bc);
    @(posedge CLK100MHZ);
    conv(16'hFFFF, 0, 16'h0, lat, bc);
    chk("b2b_lat", 32'(lat), 32'd18);
    chk("b2b_val", 32'({signo, bcd}), 32'h100001);
    repeat (2) @(posedge CLK100MHZ);

    // Start coincident with the done cycle is dropped.
    conv(16'h0042, 0, 16'h0, lat, bc);
    d0       = done_cnt;
    start    = 1'b1;
    producto = 16'h7777;
    @(posedge CLK100MHZ);
    #1;
    start = 1'b0;
    chk("coinc_busy", 32'(busy), 32'd0);
    repeat (22) @(posedge CLK100MHZ);
    #1;
    chk("coinc_no_done", 32'(done_cnt), 32'(d0 + 1));

    for (int i = 0; i < 4; i++) begin
      conv(16'($urandom), 0, 16'h0, lat, bc);
      chk("rand_lat", 32'(lat), 32'd18);
      repeat (1 + (i % 2)) @(posedge CLK100MHZ);
    end

    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("hold",        32'(hold_err),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
